// File: rtl/store_pkg.sv
// rtl/store_pkg.sv - size encodings and strobe/legality helpers for the store path
package store_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'd0,
        SZ_HALF  = 2'd1,
        SZ_WORD  = 2'd2,
        SZ_DWORD = 2'd3
    } size_e;

    // Strobe for up to an 8-byte lane group; callers truncate to their bus width.
    function automatic logic [7:0] size_strobe(input logic [1:0] size, input logic [2:0] off);
        logic [15:0] m;
        m = (16'd1 << (4'd1 << size)) - 16'd1;
        m = m << off;
        return m[7:0];
    endfunction

    function automatic logic size_legal(input logic [1:0] size, input logic [2:0] off,
                                        input int unsigned lane_bits);
        logic [2:0] mask;
        mask = 3'((4'd1 << size) - 4'd1);
        return (32'(size) <= lane_bits) && ((off & mask) == 3'd0);
    endfunction

endpackage

// File: rtl/store_lane_align.sv
// rtl/store_lane_align.sv - combinational strobe, aligned address and lane-replicated data
module store_lane_align
    import store_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic [1:0]          size,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic                legal,
    output logic [DATA_W/8-1:0] strobe,
    output logic [ADDR_W-1:0]   aligned_addr,
    output logic [DATA_W-1:0]   rep_data
);
    localparam int NB = DATA_W / 8;
    localparam int LB = $clog2(NB);

    logic [7:0] strobe8;

    always_comb begin
        strobe8      = size_strobe(size, 3'(addr[LB-1:0]));
        strobe       = legal ? strobe8[NB-1:0] : '0;
        aligned_addr = addr & ~ADDR_W'(NB - 1);
        rep_data     = '0;
        // Each lane takes the source byte at (lane mod access size).
        for (int i = 0; i < NB; i++) begin
            rep_data[8*i +: 8] = wdata[8*(i & ((1 << size) - 1)) +: 8];
        end
    end

endmodule

// File: rtl/store_write_buffer.sv
// rtl/store_write_buffer.sv - store alignment, merging in-order write buffer and load-hit detect
module store_write_buffer
    import store_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [1:0]              req_size,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [DATA_W-1:0]       req_wdata,
    output logic                    ades,
    output logic [ADDR_W-1:0]       badvaddr,
    output logic                    mem_valid,
    input  logic                    mem_ready,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    output logic [DATA_W/8-1:0]     mem_wstrb,
    input  logic [ADDR_W-1:0]       ld_addr,
    output logic                    ld_hit,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int NB = DATA_W / 8;
    localparam int LB = $clog2(NB);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] ent_addr_q [DEPTH];
    logic [ADDR_W-1:0] ent_addr_d [DEPTH];
    logic [DATA_W-1:0] ent_data_q [DEPTH];
    logic [DATA_W-1:0] ent_data_d [DEPTH];
    logic [NB-1:0]     ent_strb_q [DEPTH];
    logic [NB-1:0]     ent_strb_d [DEPTH];
    logic [DEPTH-1:0]  ent_vld_q, ent_vld_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, tail;
    logic [CW-1:0]     count_q, count_d;
    logic              ades_q, ades_d;
    logic [ADDR_W-1:0] badvaddr_q, badvaddr_d;

    logic              legal, accept, merge, push, pop;
    logic [NB-1:0]     strobe;
    logic [ADDR_W-1:0] al_addr, ld_al_addr;
    logic [DATA_W-1:0] rep_data;

    assign legal = size_legal(req_size, 3'(req_addr[LB-1:0]), LB);

    store_lane_align #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_align (
        .size         (req_size),
        .addr         (req_addr),
        .wdata        (req_wdata),
        .legal        (legal),
        .strobe       (strobe),
        .aligned_addr (al_addr),
        .rep_data     (rep_data)
    );

    always_comb begin
        req_ready = !rst && (count_q != CW'(DEPTH));
        tail      = wr_ptr_q - 1'b1;
        accept    = req_valid && req_ready;
        // Merging needs count >= 2 so the tail is never the head being presented.
        merge     = accept && legal && (count_q >= CW'(2)) && (ent_addr_q[tail] == al_addr);
        push      = accept && legal && !merge;
        pop       = mem_valid && mem_ready;

        ent_addr_d = ent_addr_q;
        ent_data_d = ent_data_q;
        ent_strb_d = ent_strb_q;
        ent_vld_d  = ent_vld_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        ades_d     = accept && !legal;
        badvaddr_d = (accept && !legal) ? req_addr : badvaddr_q;

        if (pop) begin
            ent_vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d            = rd_ptr_q + 1'b1;
        end
        if (push) begin
            ent_addr_d[wr_ptr_q] = al_addr;
            ent_data_d[wr_ptr_q] = rep_data;
            ent_strb_d[wr_ptr_q] = strobe;
            ent_vld_d[wr_ptr_q]  = 1'b1;
            wr_ptr_d             = wr_ptr_q + 1'b1;
        end
        if (merge) begin
            ent_strb_d[tail] = ent_strb_q[tail] | strobe;
            for (int i = 0; i < NB; i++) begin
                if (strobe[i]) ent_data_d[tail][8*i +: 8] = rep_data[8*i +: 8];
            end
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_addr_q[i] <= '0;
                ent_data_q[i] <= '0;
                ent_strb_q[i] <= '0;
            end
            ent_vld_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ades_q     <= 1'b0;
            badvaddr_q <= '0;
        end else begin
            ent_addr_q <= ent_addr_d;
            ent_data_q <= ent_data_d;
            ent_strb_q <= ent_strb_d;
            ent_vld_q  <= ent_vld_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ades_q     <= ades_d;
            badvaddr_q <= badvaddr_d;
        end
    end

    always_comb begin
        ld_al_addr = ld_addr & ~ADDR_W'(NB - 1);
        ld_hit     = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld_q[i] && (ent_addr_q[i] == ld_al_addr)) ld_hit = 1'b1;
        end
    end

    assign mem_valid = (count_q != '0);
    assign mem_addr  = ent_addr_q[rd_ptr_q];
    assign mem_wdata = ent_data_q[rd_ptr_q];
    assign mem_wstrb = ent_strb_q[rd_ptr_q];
    assign count     = count_q;
    assign ades      = ades_q;
    assign badvaddr  = badvaddr_q;

endmodule

// File: tb/tb_store_write_buffer.sv
// tb/tb_store_write_buffer.sv - directed self-checking bench for store_write_buffer
module tb_store_write_buffer;

    logic        clk = 1'b0;
    logic        rst, req_valid, req_ready, ades, mem_valid, mem_ready, ld_hit;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata, badvaddr, mem_addr, mem_wdata, ld_addr;
    logic [3:0]  mem_wstrb;
    logic [2:0]  count;

    int tests = 0;
    int fails = 0;
    int xfers = 0;
    int x0;

    store_write_buffer #(.DATA_W(32), .ADDR_W(32), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_size  (req_size),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .ades      (ades),
        .badvaddr  (badvaddr),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .ld_addr   (ld_addr),
        .ld_hit    (ld_hit),
        .count     (count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && mem_valid && mem_ready) xfers <= xfers + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        req_valid = 1'b1;
        req_size  = sz;
        req_addr  = a;
        req_wdata = d;
        step();
        req_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_size = 2'd0; req_addr = '0; req_wdata = '0;
        mem_ready = 1'b0; ld_addr = '0;
        step();
        chk("ready_in_reset", req_ready, 1'b0);
        step();
        rst = 1'b0;
        #1;
        chk("rst_count", count, 3'd0);
        chk("rst_mem_valid", mem_valid, 1'b0);
        chk("rst_ades", ades, 1'b0);
        chk("rst_badvaddr", badvaddr, 32'h0);
        chk("rst_ld_hit", ld_hit, 1'b0);
        chk("rst_ready_after", req_ready, 1'b1);

        // Byte store to the top lane, then back-to-back push and pop
        mem_ready = 1'b1;
        put(2'd0, 32'h1003, 32'h000000AB);
        chk("sb_valid", mem_valid, 1'b1);
        chk("sb_addr", mem_addr, 32'h1000);
        chk("sb_wstrb", mem_wstrb, 4'b1000);
        chk("sb_wdata", mem_wdata, 32'hABABABAB);
        chk("sb_count", count, 3'd1);
        put(2'd0, 32'h1000, 32'h000000CD);
        chk("pp_count", count, 3'd1);
        chk("pp_wstrb", mem_wstrb, 4'b0001);
        chk("pp_wdata", mem_wdata, 32'hCDCDCDCD);
        step();
        chk("pp_drained", count, 3'd0);
        chk("pp_valid0", mem_valid, 1'b0);

        // Misaligned and illegal-size stores
        put(2'd1, 32'h2001, 32'h1234);
        chk("sh_ades", ades, 1'b1);
        chk("sh_badv", badvaddr, 32'h2001);
        chk("sh_count", count, 3'd0);
        step();
        chk("sh_ades_pulse", ades, 1'b0);
        chk("sh_badv_hold", badvaddr, 32'h2001);
        put(2'd2, 32'h2002, 32'h5678);
        chk("sw_ades", ades, 1'b1);
        chk("sw_badv", badvaddr, 32'h2002);
        put(2'd3, 32'h3000, 32'h9);
        chk("sd_ades", ades, 1'b1);
        chk("sd_badv", badvaddr, 32'h3000);
        step();
        chk("sd_ades_off", ades, 1'b0);
        chk("fault_count", count, 3'd0);

        // Merge into tail with two entries buffered
        mem_ready = 1'b0;
        put(2'd2, 32'h10, 32'h11111111);
        put(2'd0, 32'h20, 32'h22);
        put(2'd0, 32'h21, 32'h33);
        chk("mg_count", count, 3'd2);
        chk("mg_head_addr", mem_addr, 32'h10);
        chk("mg_head_strb", mem_wstrb, 4'b1111);
        x0 = xfers;
        mem_ready = 1'b1;
        step();
        chk("mg_e2_addr", mem_addr, 32'h20);
        chk("mg_e2_strb", mem_wstrb, 4'b0011);
        chk("mg_e2_data", mem_wdata & 32'hFFFF, 32'h3322);
        chk("mg_e2_count", count, 3'd1);
        step();
        chk("mg_drained", count, 3'd0);
        chk("mg_xfers", xfers - x0, 2);

        // No merge into a lone head; load-hit visibility; merge on tail
        mem_ready = 1'b0;
        put(2'd2, 32'h40, 32'hAAAAAAAA);
        put(2'd0, 32'h41, 32'h55);
        chk("nohead_count", count, 3'd2);
        ld_addr = 32'h42;
        #1;
        chk("ld_hit_42", ld_hit, 1'b1);
        ld_addr = 32'h44;
        #1;
        chk("ld_miss_44", ld_hit, 1'b0);
        put(2'd1, 32'h44, 32'h1111);
        chk("ld_hit_44_next", ld_hit, 1'b1);
        chk("h44_count", count, 3'd3);
        put(2'd0, 32'h46, 32'h77);
        chk("tail_merge_count", count, 3'd3);
        mem_ready = 1'b1;
        step();
        chk("e2_addr", mem_addr, 32'h40);
        chk("e2_strb", mem_wstrb, 4'b0010);
        chk("e2_byte", mem_wdata & 32'h0000FF00, 32'h00005500);
        step();
        chk("e3_addr", mem_addr, 32'h44);
        chk("e3_strb", mem_wstrb, 4'b0111);
        chk("e3_data", mem_wdata & 32'h00FFFFFF, 32'h00771111);
        step();
        chk("e3_drained", count, 3'd0);

        // Full buffer back-pressure
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) put(2'd2, 32'h100 + 32'(4 * i), 32'(i + 1));
        chk("full_count", count, 3'd4);
        req_valid = 1'b1; req_size = 2'd2; req_addr = 32'h110; req_wdata = 32'h5;
        #1;
        chk("full_ready", req_ready, 1'b0);
        step();
        chk("full_held", count, 3'd4);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        #1;
        chk("pop_count", count, 3'd3);
        chk("pop_ready", req_ready, 1'b1);
        chk("pop_head", mem_addr, 32'h104);
        step();
        req_valid = 1'b0;
        chk("fifth_count", count, 3'd4);

        // Reset with entries in flight and memory ready
        mem_ready = 1'b1;
        step();
        chk("pre_rst_count", count, 3'd3);
        ld_addr = 32'h108;
        #1;
        chk("pre_rst_hit", ld_hit, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        mem_ready = 1'b0;
        #1;
        chk("post_rst_count", count, 3'd0);
        chk("post_rst_valid", mem_valid, 1'b0);
        chk("post_rst_hit", ld_hit, 1'b0);
        chk("post_rst_ades", ades, 1'b0);

        put(2'd2, 32'h200, 32'hDEADBEEF);
        chk("after_rst_count", count, 3'd1);
        chk("after_rst_addr", mem_addr, 32'h200);
        chk("after_rst_data", mem_wdata, 32'hDEADBEEF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
